instr_queue_reg: RTL and testbench
==================================

Name: instr_queue_reg

Overview:
- Parametrised successor to the single-entry instruction/PC-increment latch between fetch and decode.
- Buffers up to DEPTH fetched 24-bit instructions, each with its PC+1 value, in a circular queue.
- Uses valid/ready handshakes on both sides, plus a flush for branches.
- Presents the head entry to decode as pre-split fields; fetch can run ahead while decode stalls.

Parameters:
- PC_W, 9, width of PC-increment field carried with each instruction.
- DEPTH, 4, number of queue entries; power of 2, >= 2.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  queue can accept this cycle.
- in_instr  input  24  fetched instruction word.
- in_pc_inc  input  PC_W  PC+1 of fetched instruction.
- flush  input  1  discard all queued entries (branch/redirect).
- out_valid  output  1  head entry valid.
- out_ready  input  1  decode consumes head this cycle.
- pc_inc  output  PC_W  head PC+1.
- opcode  output  6  head[23:18].
- imm_flag  output  1  head[17].
- immediate  output  9  head[16:8].
- shift  output  5  head[16:12].
- rb  output  4  head[11:8].
- ra  output  4  head[7:4].
- rt  output  4  head[3:0].
- count  output  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset, synchronous and active-high on clk:
  - rd_ptr = wr_ptr = 0 and count = 0.
  - out_valid = 0.
  - in_ready = 1 on the first cycle after reset.
  - Storage contents need not be cleared.
- Reset mid-operation drops every entry. Reset has priority over all other inputs.
- Push fires when in_valid && in_ready:
  - Stores {in_instr, in_pc_inc} at wr_ptr.
  - wr_ptr increments modulo DEPTH and wraps DEPTH-1 -> 0.
- Pop fires when out_valid && out_ready. rd_ptr increments modulo DEPTH.
- in_ready = (count < DEPTH). It is combinational from registered count only; it does not look at out_ready in the same cycle. Therefore a full queue refuses a push even when a pop occurs that cycle.
- out_valid = (count != 0).
- Decoded outputs are combinational slices of the head entry. When out_valid = 0, all decoded outputs and pc_inc are forced to 0, so a NOP is presented.
- Latency: an entry pushed at edge N is visible on the outputs after edge N, i.e. the next cycle, when the queue was empty.
- Count update:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop together: unchanged; both pointers advance.
- Flush takes effect at the next edge:
  - Sets rd_ptr = wr_ptr = 0 and count = 0.
  - Takes priority over a same-cycle push, whose data is dropped, and over a same-cycle pop.
  - in_ready stays as computed from current count. Fetch treats a flush-cycle push as discarded.
- Boundaries:
  - Pop with out_valid = 0 is ignored.
  - Push with in_ready = 0 is ignored; storage and pointers are unchanged.
  - count never exceeds DEPTH and never underflows.
- FIFO order is strictly preserved across pointer wrap.

Optional Feature:
- Macro IQ_BYPASS_EN.
- When defined, and count == 0 and in_valid = 1 and flush = 0:
  - Outputs show in_instr/in_pc_inc combinationally.
  - out_valid = 1.
  - If out_ready = 1 that cycle, the instruction is consumed without being written; pointers and count are unchanged.
  - If out_ready = 0, a normal push occurs.
- Zero-latency empty-queue path.
- When undefined, behaviour is exactly as above: minimum latency of 1 cycle, no combinational in->out path.

Test Plan:
- Reset:
  - Stimulus: assert rst for 2 cycles with in_valid = 1.
  - Required: count = 0, out_valid = 0, opcode = 0, pc_inc = 0, in_ready = 1 after release.
- Single push:
  - Stimulus: push in_instr = 24'hA5_3C_71, in_pc_inc = 9'h012 into an empty queue.
  - Required: next cycle opcode = 6'h29, imm_flag = 0, immediate = 9'h13C, shift = 5'h13, rb = 4'hC, ra = 4'h7, rt = 4'h1, pc_inc = 9'h012.
- Fill with DEPTH = 4:
  - Stimulus: push 4 entries with out_ready = 0.
  - Required: count = 4, in_ready = 0; a 5th push is ignored.
  - Then drain with out_ready = 1: the 4 entries emerge in order over 4 cycles, then out_valid = 0.
- Wrap:
  - Stimulus: 10 cycles of continuous push+pop after priming 2 entries.
  - Required: count stays 2 and the sequence is preserved across wrap.
- Flush:
  - Stimulus: with count = 3, assert flush together with a push and a pop.
  - Required: next cycle count = 0, out_valid = 0; the flush-cycle pushed word never appears.
- IQ_BYPASS_EN:
  - Stimulus: empty queue, in_valid = 1, out_ready = 1, in_instr = 24'h04_00_21.
  - Required: same-cycle opcode = 6'h01, rt = 4'h1, count stays 0.
  - Without the macro: out_valid = 0 that cycle, then 1 the next cycle.

Source files
------------

// File: rtl/instr_queue_reg.sv
// instr_queue_reg
//   Circular instruction queue between fetch and decode. It holds up to DEPTH
//   24-bit instructions, each stored with its PC+1 value, and presents the
//   head entry to decode as pre-split fields. Fetch can keep pushing while
//   decode stalls. A flush (branch/redirect) discards every queued entry.
//
// Parameters
//   PC_W   width of the PC+1 field carried with each instruction
//   DEPTH  number of queue entries (power of 2, >= 2)
//
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    fetch-side handshake
//   in_instr, in_pc_inc  fetched word and its PC+1
//   flush                drops all entries at the next edge
//   out_valid/out_ready  decode-side handshake on the head entry
//   pc_inc, opcode, imm_flag, immediate, shift, rb, ra, rt
//                        head entry fields; all zero (a NOP) when out_valid=0
//   count                occupancy, 0..DEPTH
//
// Optional build macro
//   IQ_BYPASS_EN  When the queue is empty, presents the incoming fetch word
//                 straight to decode in the same cycle. If decode takes it,
//                 the word is never written into the queue.
module instr_queue_reg #(
    parameter int unsigned PC_W  = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [23:0]              in_instr,
    input  logic [PC_W-1:0]          in_pc_inc,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          pc_inc,
    output logic [5:0]               opcode,
    output logic                     imm_flag,
    output logic [8:0]               immediate,
    output logic [4:0]               shift,
    output logic [3:0]               rb,
    output logic [3:0]               ra,
    output logic [3:0]               rt,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [23:0]     instr;
        logic [PC_W-1:0] pc_inc;
    } entry_t;

    // Queue state
    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    // Handshake and datapath signals
    entry_t in_entry_c;
    entry_t head_raw_c;
    entry_t head_c;
    logic   full_c;
    logic   byp_c;
    logic   push_c;
    logic   pop_c;
    logic   wr_en_c;
    logic   rd_en_c;

    // Fetch-side word packed into the storage layout
    always_comb begin
        in_entry_c        = '0;
        in_entry_c.instr  = in_instr;
        in_entry_c.pc_inc = in_pc_inc;
    end

    // Handshakes; in_ready depends only on registered occupancy, so a full
    // queue refuses a push even in a cycle where decode pops.
    always_comb begin
        full_c    = (count_q == CNT_W'(DEPTH));
        in_ready  = !full_c;
        byp_c     = 1'b0;
`ifdef IQ_BYPASS_EN
        byp_c     = (count_q == '0) && in_valid && !flush;
`endif
        out_valid = (count_q != '0) || byp_c;
        push_c    = in_valid && in_ready;
        pop_c     = out_valid && out_ready;
        // A bypassed word consumed by decode never enters storage, and a
        // bypass pop does not remove anything from storage.
        wr_en_c   = push_c && !(byp_c && out_ready);
        rd_en_c   = pop_c && !byp_c;
    end

    // Head selection; a NOP (all zero) is shown whenever nothing is valid
    always_comb begin
        head_raw_c = mem_q[rd_ptr_q];
        if (byp_c) begin
            head_raw_c = in_entry_c;
        end
        head_c = out_valid ? head_raw_c : '0;
    end

    // Decode field split of the head entry
    always_comb begin
        pc_inc    = head_c.pc_inc;
        opcode    = head_c.instr[23:18];
        imm_flag  = head_c.instr[17];
        immediate = head_c.instr[16:8];
        shift     = head_c.instr[16:12];
        rb        = head_c.instr[11:8];
        ra        = head_c.instr[7:4];
        rt        = head_c.instr[3:0];
        count     = count_q;
    end

    // Pointer and occupancy next state; flush beats any same-cycle push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of 2, so natural pointer overflow wraps DEPTH-1 -> 0
            if (wr_en_c) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (rd_en_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({wr_en_c, rd_en_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; entries only become visible through count
    always_ff @(posedge clk) begin
        if (!rst && !flush && wr_en_c) begin
            mem_q[wr_ptr_q] <= in_entry_c;
        end
    end

endmodule

// File: tb/tb_instr_queue_reg.sv
// Self-checking bench for instr_queue_reg: a queue-based reference model is
// compared with the DUT every cycle, and directed sections pin the model with
// hand-computed literal values before a long randomized run.
module tb_instr_queue_reg;

    localparam int unsigned PC_W  = 9;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [23:0]      in_instr;
    logic [PC_W-1:0]  in_pc_inc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [PC_W-1:0]  pc_inc;
    logic [5:0]       opcode;
    logic             imm_flag;
    logic [8:0]       immediate;
    logic [4:0]       shift;
    logic [3:0]       rb;
    logic [3:0]       ra;
    logic [3:0]       rt;
    logic [CNT_W-1:0] count;

    instr_queue_reg #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc_inc (in_pc_inc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pc_inc    (pc_inc),
        .opcode    (opcode),
        .imm_flag  (imm_flag),
        .immediate (immediate),
        .shift     (shift),
        .rb        (rb),
        .ra        (ra),
        .rt        (rt),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;
    bit chk_en = 1'b0;

    // Reference model: queue of {instr, pc_inc}
    logic [24+PC_W-1:0] mq[$];
    logic [24+PC_W-1:0] m_head;
    logic               m_valid;
    logic               m_byp;
    logic               m_push;
    logic               m_pop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] dut_instr();
        return {opcode, imm_flag, immediate, ra, rt};
    endfunction

    function automatic logic model_bypass();
        logic b;
        b = 1'b0;
`ifdef IQ_BYPASS_EN
        b = (mq.size() == 0) && in_valid && !flush;
`endif
        return b;
    endfunction

    // Model state update, using the inputs held across the edge
    always @(posedge clk) begin
        if (rst || flush) begin
            mq.delete();
        end else begin
            m_byp  = model_bypass();
            m_pop  = (mq.size() != 0) && out_ready;
            m_push = in_valid && (mq.size() < int'(DEPTH)) && !(m_byp && out_ready);
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back({in_instr, in_pc_inc});
        end
    end

    // Compare process: all outputs against the model, mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            m_byp   = model_bypass();
            m_valid = (mq.size() != 0) || m_byp;
            m_head  = '0;
            if (m_byp) m_head = {in_instr, in_pc_inc};
            else if (mq.size() != 0) m_head = mq[0];
            chk("in_ready",  32'(in_ready),  32'(mq.size() < int'(DEPTH)));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("count",     32'(count),     32'(mq.size()));
            chk("pc_inc",    32'(pc_inc),    32'(m_head[PC_W-1:0]));
            chk("opcode",    32'(opcode),    32'(m_head[PC_W+23:PC_W+18]));
            chk("imm_flag",  32'(imm_flag),  32'(m_head[PC_W+17]));
            chk("immediate", 32'(immediate), 32'(m_head[PC_W+16:PC_W+8]));
            chk("shift",     32'(shift),     32'(m_head[PC_W+16:PC_W+12]));
            chk("rb",        32'(rb),        32'(m_head[PC_W+11:PC_W+8]));
            chk("ra",        32'(ra),        32'(m_head[PC_W+7:PC_W+4]));
            chk("rt",        32'(rt),        32'(m_head[PC_W+3:PC_W]));
        end
    end

    task automatic drive(input logic r, input logic iv, input logic [23:0] ins,
                         input logic [PC_W-1:0] pc, input logic fl, input logic ordy);
        rst       = r;
        in_valid  = iv;
        in_instr  = ins;
        in_pc_inc = pc;
        flush     = fl;
        out_ready = ordy;
    endtask

    // Finish the current cycle; returns just after the next rising edge
    task automatic fin();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 24'h0, '0, 1'b0, 1'b0);
        #1;
    endtask

    logic [23:0] w [12];

    initial begin
        // Reset for 2 cycles with in_valid high
        drive(1'b1, 1'b1, 24'h123456, 9'h1AA, 1'b0, 1'b0);
        fin();
        chk_en = 1'b1;
        drive(1'b1, 1'b1, 24'h654321, 9'h055, 1'b0, 1'b0);
        fin();
        idle();
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_opcode",    32'(opcode),    32'd0);
        chk("rst_pc_inc",    32'(pc_inc),    32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);

        // Single push, field split checked by hand
        drive(1'b0, 1'b1, 24'hA53C71, 9'h012, 1'b0, 1'b0);
        fin();
        idle();
        chk("sp_opcode",    32'(opcode),    32'h29);
        chk("sp_imm_flag",  32'(imm_flag),  32'h0);
        chk("sp_immediate", 32'(immediate), 32'h13C);
        chk("sp_shift",     32'(shift),     32'h13);
        chk("sp_rb",        32'(rb),        32'hC);
        chk("sp_ra",        32'(ra),        32'h7);
        chk("sp_rt",        32'(rt),        32'h1);
        chk("sp_pc_inc",    32'(pc_inc),    32'h012);
        drive(1'b0, 1'b0, 24'h0, '0, 1'b0, 1'b1);
        fin();

        // Fill to DEPTH, refuse a 5th push, then drain in order
        for (int i = 0; i < 4; i++) begin
            w[i] = 24'($urandom);
            drive(1'b0, 1'b1, w[i], PC_W'(i), 1'b0, 1'b0);
            fin();
        end
        idle();
        chk("fill_count",    32'(count),    32'd4);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        drive(1'b0, 1'b1, 24'hBADBAD, 9'h1FF, 1'b0, 1'b0);
        fin();
        idle();
        chk("fill_5th_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 24'h0, '0, 1'b0, 1'b1);
            #1;
            chk("drain_order", 32'(dut_instr()), 32'(w[i]));
            fin();
        end
        idle();
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Continuous push+pop across pointer wrap with 2 entries resident
        for (int i = 0; i < 12; i++) w[i] = 24'($urandom);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, w[i], PC_W'(i), 1'b0, 1'b0);
            fin();
        end
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b1, w[k+2], PC_W'(k + 2), 1'b0, 1'b1);
            #1;
            chk("wrap_order", 32'(dut_instr()), 32'(w[k]));
            chk("wrap_count", 32'(count), 32'd2);
            fin();
        end
        for (int k = 10; k < 12; k++) begin
            drive(1'b0, 1'b0, 24'h0, '0, 1'b0, 1'b1);
            #1;
            chk("wrap_tail", 32'(dut_instr()), 32'(w[k]));
            fin();
        end

        // Flush with count = 3 together with a push and a pop
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 24'($urandom), PC_W'(i), 1'b0, 1'b0);
            fin();
        end
        idle();
        chk("fl_pre_count", 32'(count), 32'd3);
        drive(1'b0, 1'b1, 24'hFFFFFF, 9'h1FF, 1'b1, 1'b1);
        fin();
        idle();
        chk("fl_count",     32'(count),     32'd0);
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 24'h0, '0, 1'b0, 1'b1);
            fin();
            idle();
            chk("fl_no_ghost", 32'(out_valid), 32'd0);
        end

        // Empty-queue path, same-cycle consume attempt
        drive(1'b0, 1'b1, 24'h040021, 9'h033, 1'b0, 1'b1);
        #1;
`ifdef IQ_BYPASS_EN
        chk("byp_out_valid", 32'(out_valid), 32'd1);
        chk("byp_opcode",    32'(opcode),    32'h01);
        chk("byp_rt",        32'(rt),        32'h1);
        chk("byp_count",     32'(count),     32'd0);
        fin();
        idle();
        chk("byp_count_after", 32'(count), 32'd0);
`else
        chk("nobyp_out_valid", 32'(out_valid), 32'd0);
        fin();
        idle();
        chk("nobyp_next_valid",  32'(out_valid), 32'd1);
        chk("nobyp_next_opcode", 32'(opcode),    32'h01);
        chk("nobyp_next_rt",     32'(rt),        32'h1);
        chk("nobyp_next_count",  32'(count),     32'd1);
        drive(1'b0, 1'b0, 24'h0, '0, 1'b0, 1'b1);
        fin();
`endif

        // Randomized traffic, including occasional flush and mid-run reset
        for (int c = 0; c < 3000; c++) begin
            drive(1'($urandom_range(0, 99) == 0),
                  1'($urandom_range(0, 9) < 7),
                  24'($urandom),
                  PC_W'($urandom),
                  1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 9) < 5));
            fin();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
